// File: rtl/dig_move_ctrl_pkg.sv
// Shared constants for the digger movement controller: grid geometry,
// tile codes, keypad direction codes and the controller state encoding.
package dig_move_ctrl_pkg;

   localparam int unsigned COLS  = 15;
   localparam int unsigned ROWS  = 10;
   localparam int unsigned CELLS = COLS * ROWS;
   localparam int unsigned AW    = 8;
   localparam int unsigned DW    = 4;
   localparam int unsigned KW    = 3;
   localparam int unsigned RCW   = 4;   // row / column index width
   localparam int unsigned SCW   = 8;   // scan counter width, holds 0..CELLS

   localparam logic [DW-1:0] TILE_TUNNEL    = 4'd0;
   localparam logic [DW-1:0] TILE_DIG_UP    = 4'd1;
   localparam logic [DW-1:0] TILE_DIG_DOWN  = 4'd2;
   localparam logic [DW-1:0] TILE_DIG_LEFT  = 4'd3;
   localparam logic [DW-1:0] TILE_DIG_RIGHT = 4'd4;
   localparam logic [DW-1:0] TILE_DIRT      = 4'd5;
   localparam logic [DW-1:0] TILE_EMERALD   = 4'd6;
   localparam logic [DW-1:0] TILE_ROCK      = 4'd7;

   // Direction key codes equal the matching digger tile codes.
   localparam logic [KW-1:0] KEY_NONE  = 3'd0;
   localparam logic [KW-1:0] KEY_UP    = 3'd1;
   localparam logic [KW-1:0] KEY_DOWN  = 3'd2;
   localparam logic [KW-1:0] KEY_LEFT  = 3'd3;
   localparam logic [KW-1:0] KEY_RIGHT = 3'd4;

   typedef enum logic [2:0] {
      ST_SCAN,
      ST_IDLE,
      ST_RD_TGT,
      ST_EVAL,
      ST_WR_OLD,
      ST_WR_NEW,
      ST_WR_TURN,
      ST_FAIL
   } state_t;

   function automatic logic key_is_move(input logic [KW-1:0] k);
      return (k >= KEY_UP) && (k <= KEY_RIGHT);
   endfunction

   function automatic logic tile_is_digger(input logic [DW-1:0] t);
      return (t >= TILE_DIG_UP) && (t <= TILE_DIG_RIGHT);
   endfunction

endpackage

// File: rtl/dig_target_calc.sv
// Combinational neighbour calculation for a move request.
// Ports: row/col/digpos - current digger location; dir - direction key code;
//        target_c - neighbouring cell index; blocked_c - move would leave the grid.
module dig_target_calc
   import dig_move_ctrl_pkg::*;
(
   input  logic [RCW-1:0] row,
   input  logic [RCW-1:0] col,
   input  logic [AW-1:0]  digpos,
   input  logic [KW-1:0]  dir,
   output logic [AW-1:0]  target_c,
   output logic           blocked_c
);

   always_comb begin
      target_c  = digpos;
      blocked_c = 1'b1;
      case (dir)
         KEY_UP: begin
            blocked_c = (row == '0);
            target_c  = digpos - AW'(COLS);
         end
         KEY_DOWN: begin
            blocked_c = (row == RCW'(ROWS - 1));
            target_c  = digpos + AW'(COLS);
         end
         KEY_LEFT: begin
            blocked_c = (col == '0);
            target_c  = digpos - AW'(1);
         end
         KEY_RIGHT: begin
            blocked_c = (col == RCW'(COLS - 1));
            target_c  = digpos + AW'(1);
         end
         default: begin
            target_c  = digpos;
            blocked_c = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/dig_move_ctrl.sv
// Digger movement controller: owns the tile RAM port for player moves.
// After reset it scans the grid for the digger, then performs
// read-check-write sequences for accepted move requests.
// Ports: test_clk/rst - clock and synchronous active-high reset;
//        key/move_tick - direction code and move strobe from the keypad;
//        vgaram_* - single-port tile RAM (read data one cycle after address);
//        digpos - digger cell; busy - scanning or moving;
//        no_digger - scan found no digger; emerald_cnt - saturating collect count.
module dig_move_ctrl
   import dig_move_ctrl_pkg::*;
(
   input  logic          test_clk,
   input  logic          rst,
   input  logic [KW-1:0] key,
   input  logic          move_tick,
   input  logic [DW-1:0] vgaram_douta,
   output logic          vgaram_we,
   output logic [AW-1:0] vgaram_addra,
   output logic [DW-1:0] vgaram_dina,
   output logic [AW-1:0] digpos,
   output logic          busy,
   output logic          no_digger,
   output logic [7:0]    emerald_cnt
);

   state_t          state;
   logic [RCW-1:0]  row, col;
   logic [KW-1:0]   dir;
   logic [AW-1:0]   target;
   logic            collect;
   logic [SCW-1:0]  scan_cnt;
   logic            found;
   logic [RCW-1:0]  scan_row, scan_col;
   logic [AW-1:0]   tc_target_c;
   logic            tc_blocked_c;
   logic            scan_hit_c;

   dig_target_calc u_target (
      .row       (row),
      .col       (col),
      .digpos    (digpos),
      .dir       (key),
      .target_c  (tc_target_c),
      .blocked_c (tc_blocked_c)
   );

   // Read data in SCAN belongs to address scan_cnt-1; nothing is valid at scan_cnt 0.
   assign scan_hit_c = (scan_cnt != '0) && tile_is_digger(vgaram_douta);

   // Controller FSM with registered RAM port and status outputs.
   always_ff @(posedge test_clk) begin
      if (rst) begin
         state        <= ST_SCAN;
         vgaram_we    <= 1'b0;
         vgaram_addra <= '0;
         vgaram_dina  <= '0;
         digpos       <= '0;
         busy         <= 1'b1;
         no_digger    <= 1'b0;
         emerald_cnt  <= '0;
         row          <= '0;
         col          <= '0;
         dir          <= KEY_NONE;
         target       <= '0;
         collect      <= 1'b0;
         scan_cnt     <= '0;
         found        <= 1'b0;
         scan_row     <= '0;
         scan_col     <= '0;
      end else begin
         vgaram_we <= 1'b0;
         case (state)
            ST_SCAN: begin
               if (scan_hit_c && !found) begin
                  found  <= 1'b1;
                  digpos <= AW'(scan_cnt - SCW'(1));
                  row    <= scan_row;
                  col    <= scan_col;
               end
               // scan_row/scan_col follow the address whose data is being checked.
               if (scan_cnt != '0) begin
                  if (scan_col == RCW'(COLS - 1)) begin
                     scan_col <= '0;
                     scan_row <= scan_row + RCW'(1);
                  end else begin
                     scan_col <= scan_col + RCW'(1);
                  end
               end
               if (scan_cnt == SCW'(CELLS)) begin
                  vgaram_addra <= '0;
                  busy         <= 1'b0;
                  if (found || scan_hit_c) begin
                     state <= ST_IDLE;
                  end else begin
                     state     <= ST_FAIL;
                     no_digger <= 1'b1;
                  end
               end else begin
                  scan_cnt     <= scan_cnt + SCW'(1);
                  vgaram_addra <= (scan_cnt == SCW'(CELLS - 1)) ? '0 : AW'(scan_cnt + SCW'(1));
               end
            end

            ST_IDLE: begin
               if (move_tick && key_is_move(key)) begin
                  dir  <= key;
                  busy <= 1'b1;
                  if (tc_blocked_c) begin
                     state        <= ST_WR_TURN;
                     vgaram_we    <= 1'b1;
                     vgaram_addra <= digpos;
                     vgaram_dina  <= DW'(key);
                  end else begin
                     state        <= ST_RD_TGT;
                     target       <= tc_target_c;
                     vgaram_addra <= tc_target_c;
                  end
               end
            end

            ST_RD_TGT: begin
               state <= ST_EVAL;
            end

            ST_EVAL: begin
               vgaram_we    <= 1'b1;
               vgaram_addra <= digpos;
               if (vgaram_douta == TILE_ROCK) begin
                  state       <= ST_WR_TURN;
                  vgaram_dina <= DW'(dir);
               end else begin
                  state       <= ST_WR_OLD;
                  vgaram_dina <= TILE_TUNNEL;
                  collect     <= (vgaram_douta == TILE_EMERALD);
               end
            end

            ST_WR_OLD: begin
               state        <= ST_WR_NEW;
               vgaram_we    <= 1'b1;
               vgaram_addra <= target;
               vgaram_dina  <= DW'(dir);
            end

            ST_WR_NEW: begin
               state   <= ST_IDLE;
               busy    <= 1'b0;
               digpos  <= target;
               collect <= 1'b0;
               case (dir)
                  KEY_UP:    row <= row - RCW'(1);
                  KEY_DOWN:  row <= row + RCW'(1);
                  KEY_LEFT:  col <= col - RCW'(1);
                  KEY_RIGHT: col <= col + RCW'(1);
                  default:   row <= row;
               endcase
               if (collect && (emerald_cnt != 8'hFF)) begin
                  emerald_cnt <= emerald_cnt + 8'd1;
               end
            end

            ST_WR_TURN: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end

            ST_FAIL: begin
               busy <= 1'b0;
            end

            default: begin
               state <= ST_SCAN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dig_move_ctrl.sv
// Directed self-checking bench for dig_move_ctrl with a behavioural tile RAM.
module tb_dig_move_ctrl;
   import dig_move_ctrl_pkg::*;

   logic          test_clk = 1'b0;
   logic          rst = 1'b1;
   logic [KW-1:0] key = KEY_NONE;
   logic          move_tick = 1'b0;
   logic [DW-1:0] vgaram_douta;
   logic          vgaram_we;
   logic [AW-1:0] vgaram_addra;
   logic [DW-1:0] vgaram_dina;
   logic [AW-1:0] digpos;
   logic          busy;
   logic          no_digger;
   logic [7:0]    emerald_cnt;

   always #5 test_clk = ~test_clk;

   dig_move_ctrl dut (
      .test_clk     (test_clk),
      .rst          (rst),
      .key          (key),
      .move_tick    (move_tick),
      .vgaram_douta (vgaram_douta),
      .vgaram_we    (vgaram_we),
      .vgaram_addra (vgaram_addra),
      .vgaram_dina  (vgaram_dina),
      .digpos       (digpos),
      .busy         (busy),
      .no_digger    (no_digger),
      .emerald_cnt  (emerald_cnt)
   );

   // Tile RAM model, image loader, single-cell poke and write log.
   logic [DW-1:0] mem [0:255];
   logic [DW-1:0] img [0:255];
   logic          load_all = 1'b0;
   logic          poke_en = 1'b0;
   logic [AW-1:0] poke_addr = '0;
   logic [DW-1:0] poke_val = '0;
   int unsigned   wr_total = 0;
   logic [AW-1:0] log_a [0:1023];
   logic [DW-1:0] log_d [0:1023];

   always @(posedge test_clk) begin
      if (load_all) begin
         for (int i = 0; i < 256; i++) mem[i] <= img[i];
      end else begin
         if (poke_en) mem[poke_addr] <= poke_val;
         if (vgaram_we) mem[vgaram_addra] <= vgaram_dina;
      end
      vgaram_douta <= mem[vgaram_addra];
      if (vgaram_we) begin
         log_a[wr_total[9:0]] <= vgaram_addra;
         log_d[wr_total[9:0]] <= vgaram_dina;
         wr_total <= wr_total + 1;
      end
   end

   int          checks = 0;
   int          errors = 0;
   int unsigned base = 0;
   int          lat;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge test_clk);
      #1;
   endtask

   task automatic fill_img(input logic [DW-1:0] v);
      for (int i = 0; i < 256; i++) img[i] = v;
   endtask

   task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
      poke_en = 1'b1; poke_addr = a; poke_val = v;
      tick();
      poke_en = 1'b0;
   endtask

   // Reset (optionally loading img), then run the scan and check its timing.
   task automatic scan_reset(input bit load, input bit exp_found);
      rst = 1'b1; load_all = load; key = KEY_NONE; move_tick = 1'b0;
      tick();
      load_all = 1'b0;
      chk("reset busy", busy, 1);
      chk("reset we", vgaram_we, 0);
      chk("reset addra", vgaram_addra, 0);
      chk("reset dina", vgaram_dina, 0);
      chk("reset digpos", digpos, 0);
      chk("reset emerald", emerald_cnt, 0);
      chk("reset no_digger", no_digger, 0);
      tick();
      rst = 1'b0;
      base = wr_total;
      repeat (150) tick();
      chk("scan busy at 150", busy, 1);
      tick();
      chk("scan busy at 151", busy, 0);
      chk("scan no_digger", no_digger, exp_found ? 0 : 1);
      chk("scan writes", wr_total - base, 0);
   endtask

   // Pulse one move request and count cycles until busy drops (0 = not accepted).
   task automatic do_move(input logic [KW-1:0] k, output int l);
      base = wr_total;
      key = k; move_tick = 1'b1;
      tick();
      key = KEY_NONE; move_tick = 1'b0;
      l = 0;
      while (busy && l < 20) begin
         tick();
         l++;
      end
   endtask

   task automatic chk_wr(input string tag, input int n, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int unsigned idx;
      idx = base + n;
      chk({tag, " addr"}, log_a[idx[9:0]], a);
      chk({tag, " data"}, log_d[idx[9:0]], d);
   endtask

   initial begin
      // Digger facing right at 37, rest dirt.
      fill_img(TILE_DIRT); img[37] = TILE_DIG_RIGHT;
      scan_reset(1'b1, 1'b1);
      chk("scan digpos 37", digpos, 37);

      // Full move right into dirt.
      do_move(KEY_RIGHT, lat);
      chk("move right latency", lat, 4);
      chk("move right writes", wr_total - base, 2);
      chk_wr("move right wr0", 0, 37, 0);
      chk_wr("move right wr1", 1, 38, 4);
      chk("move right digpos", digpos, 38);
      chk("move right no emerald", emerald_cnt, 0);
      chk("ram 37 tunnel", mem[37], 0);

      // No action without a valid key and tick.
      do_move(3'd5, lat);
      chk("key 101 ignored", lat, 0);
      do_move(KEY_NONE, lat);
      chk("key 000 ignored", lat, 0);
      base = wr_total;
      key = KEY_RIGHT; move_tick = 1'b0;
      repeat (3) tick();
      key = KEY_NONE;
      chk("no tick no writes", wr_total - base, 0);
      chk("no tick busy", busy, 0);

      // A tick during RD_TGT is dropped.
      base = wr_total;
      key = KEY_UP; move_tick = 1'b1;
      tick();
      key = KEY_DOWN; move_tick = 1'b1;
      tick();
      key = KEY_NONE; move_tick = 1'b0;
      lat = 1;
      while (busy && lat < 20) begin tick(); lat++; end
      chk("up latency", lat, 4);
      repeat (3) tick();
      chk("up writes", wr_total - base, 2);
      chk_wr("up wr0", 0, 38, 0);
      chk_wr("up wr1", 1, 23, 1);
      chk("up digpos", digpos, 23);

      // Top-edge block: one turn write, no read.
      fill_img(TILE_DIRT); img[7] = TILE_DIG_RIGHT;
      scan_reset(1'b1, 1'b1);
      do_move(KEY_UP, lat);
      chk("edge up latency", lat, 1);
      chk("edge up writes", wr_total - base, 1);
      chk_wr("edge up wr", 0, 7, 1);
      chk("edge up digpos", digpos, 7);

      // Digger in last cell, found on the final scan cycle.
      fill_img(TILE_DIRT); img[149] = TILE_DIG_DOWN;
      scan_reset(1'b1, 1'b1);
      chk("last cell digpos", digpos, 149);
      do_move(KEY_RIGHT, lat);
      chk("edge right latency", lat, 1);
      chk_wr("edge right wr", 0, 149, 4);
      do_move(KEY_DOWN, lat);
      chk("edge down latency", lat, 1);
      chk_wr("edge down wr", 0, 149, 2);
      do_move(KEY_UP, lat);
      chk("149 up latency", lat, 4);
      chk("149 up digpos", digpos, 134);
      do_move(KEY_DOWN, lat);
      chk("134 down digpos", digpos, 149);
      do_move(KEY_DOWN, lat);
      chk("row 9 down blocked", lat, 1);

      // Rock blocks a move.
      fill_img(TILE_DIRT); img[50] = TILE_DIG_UP; img[51] = TILE_ROCK;
      scan_reset(1'b1, 1'b1);
      do_move(KEY_RIGHT, lat);
      chk("rock latency", lat, 3);
      chk("rock writes", wr_total - base, 1);
      chk_wr("rock wr", 0, 50, 4);
      chk("rock digpos", digpos, 50);
      chk("rock kept", mem[51], 7);

      // Emerald collection and saturation.
      fill_img(TILE_DIRT); img[50] = TILE_DIG_RIGHT; img[49] = TILE_EMERALD;
      scan_reset(1'b1, 1'b1);
      do_move(KEY_LEFT, lat);
      chk("emerald latency", lat, 4);
      chk_wr("emerald wr0", 0, 50, 0);
      chk_wr("emerald wr1", 1, 49, 3);
      chk("emerald count 1", emerald_cnt, 1);
      for (int i = 0; i < 254; i++) begin
         if (i % 2 == 0) begin
            poke(50, TILE_EMERALD); do_move(KEY_RIGHT, lat);
         end else begin
            poke(49, TILE_EMERALD); do_move(KEY_LEFT, lat);
         end
      end
      chk("emerald count 255", emerald_cnt, 255);
      poke(50, TILE_EMERALD);
      do_move(KEY_RIGHT, lat);
      chk("emerald saturated", emerald_cnt, 255);
      chk("emerald digpos", digpos, 50);

      // Reset between WR_OLD and WR_NEW: digger erased, rescan fails.
      key = KEY_LEFT; move_tick = 1'b1;
      tick();
      key = KEY_NONE; move_tick = 1'b0;
      tick();
      tick();
      chk("wr_old we", vgaram_we, 1);
      chk("wr_old addra", vgaram_addra, 50);
      chk("wr_old dina", vgaram_dina, 0);
      rst = 1'b1;
      tick();
      scan_reset(1'b0, 1'b0);
      chk("abort cell 50", mem[50], 0);
      chk("abort cell 49", mem[49], 0);
      do_move(KEY_RIGHT, lat);
      chk("fail ignores right", lat, 0);
      do_move(KEY_UP, lat);
      repeat (3) tick();
      chk("fail no writes", wr_total - base, 0);
      chk("fail no_digger held", no_digger, 1);

      // All-dirt grid.
      fill_img(TILE_DIRT);
      scan_reset(1'b1, 1'b0);
      do_move(KEY_LEFT, lat);
      do_move(KEY_DOWN, lat);
      repeat (3) tick();
      chk("dirt fail no writes", wr_total - base, 0);
      chk("dirt fail busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
